// File: rtl/adc_pack_pkg.sv
// adc_pack_pkg: shared FSM encoding, default geometry and strobe length for the ADC frame packer
package adc_pack_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, DRAIN = 2'd2} state_e;
  localparam int WORD_W = 128;
  localparam int STROBE_CYC = 4;
  localparam int LANES = WORD_W / 16;
  localparam int FRAME_WORDS = 256 * 1000;
  localparam int CNT_W = $clog2(FRAME_WORDS + 1);
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO; a pop on empty leaves pointers alone, full accepts a push alongside a pop
module sync_fifo_fwft #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic do_push, do_pop;
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || pop);
  assign dout = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  always_comb begin
    wr_ptr_d = flush ? '0 : wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/adc_frame_packer.sv
// adc_frame_packer: packs ADC samples LSB-first into 128-bit words, buffers them and feeds one frame to the AXI master
module adc_frame_packer
  import adc_pack_pkg::*;
#(
  parameter int SAMPLE_W    = 16,
  parameter int BURST_LEN   = 256,
  parameter int BURST_TIMES = 1000,
  parameter int FIFO_DEPTH  = 1024,
  parameter int START_WORDS = 512
) (
  input  logic                M_AXI_ACLK,
  input  logic                M_AXI_ARESET,
  input  logic                capture_start,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic                adc_valid,
  output logic [WORD_W-1:0]   data_trans,
  input  logic                data_ready_trans,
  output logic                data_trans_signal,
  output logic                capture_busy,
  output logic                frame_done,
  output logic                overflow,
  output logic                underflow
);
  localparam int LN  = WORD_W / SAMPLE_W;
  localparam int FW  = BURST_LEN * BURST_TIMES;
  localparam int CW  = $clog2(FW + 1);
  localparam int LW  = LN > 1 ? $clog2(LN) : 1;
  localparam int SHW = WORD_W - SAMPLE_W;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  state_e state_q, state_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [SHW-1:0] shreg_q, shreg_d;
  logic [CW-1:0] words_packed_q, words_packed_d, words_popped_q, words_popped_d;
  logic [2:0] strobe_q, strobe_d;
  logic launched_q, launched_d, frame_done_q, frame_done_d;
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  logic [WORD_W-1:0] word;
  logic [FCW-1:0] fifo_count;
  logic fifo_full, fifo_empty, start, accept_s, push, pop, last_pop, launch;
  assign start = state_q == IDLE && capture_start;
  assign accept_s = state_q == CAPTURE && adc_valid && words_packed_q < CW'(FW);
  assign word = {adc_data, shreg_q};
  assign push = accept_s && lane_q == LW'(LN - 1);
  assign pop = data_ready_trans && state_q != IDLE;
  assign last_pop = pop && words_popped_q == CW'(FW - 1) && words_packed_q == CW'(FW);
  // launch on fill level or a fully packed frame, whichever first, once per frame
  assign launch = state_q != IDLE && !launched_q &&
                  (fifo_count >= FCW'(START_WORDS) || words_packed_q == CW'(FW));
  always_comb begin
    lane_d = start ? '0 : accept_s ? (push ? '0 : lane_q + LW'(1)) : lane_q;
    shreg_d = accept_s ? word[WORD_W-1:SAMPLE_W] : shreg_q;
    words_packed_d = start ? '0 : words_packed_q + CW'(push);
    words_popped_d = start ? '0 : words_popped_q + CW'(pop);
    launched_d = !start && (launched_q || launch);
    strobe_d = launch ? 3'(STROBE_CYC) : strobe_q - 3'(strobe_q != '0);
    frame_done_d = last_pop;
    overflow_d = !start && (overflow_q || (push && fifo_full && !pop));
    underflow_d = !start && (underflow_q || (pop && fifo_empty));
    state_d = state_q == IDLE ? (capture_start ? CAPTURE : IDLE) :
              last_pop ? IDLE :
              (state_q == CAPTURE && words_packed_q == CW'(FW)) ? DRAIN : state_q;
  end
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q <= IDLE;
      lane_q <= '0;
      shreg_q <= '0;
      words_packed_q <= '0;
      words_popped_q <= '0;
      strobe_q <= '0;
      launched_q <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q <= lane_d;
      shreg_q <= shreg_d;
      words_packed_q <= words_packed_d;
      words_popped_q <= words_popped_d;
      strobe_q <= strobe_d;
      launched_q <= launched_d;
      frame_done_q <= frame_done_d;
      overflow_q <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  sync_fifo_fwft #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (M_AXI_ACLK),
    .rst   (M_AXI_ARESET),
    .flush (start),
    .push  (push),
    .din   (word),
    .pop   (pop),
    .dout  (data_trans),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  assign data_trans_signal = strobe_q != '0;
  assign capture_busy = state_q != IDLE;
  assign frame_done = frame_done_q;
  assign overflow = overflow_q;
  assign underflow = underflow_q;
endmodule

// File: tb/tb_adc_frame_packer.sv
// tb_adc_frame_packer: scoreboard bench for a nominal packer and a shallow-FIFO packer
module tb_adc_frame_packer;
  logic clk = 1'b0, rst = 1'b1;
  logic n_start = 0, n_valid = 0, n_ready = 0;
  logic [15:0] n_data = '0;
  logic [127:0] n_dt;
  logic n_sig, n_busy, n_done, n_ovf, n_udf;
  logic o_start = 0, o_valid = 0, o_ready = 0;
  logic [15:0] o_data = '0;
  logic [127:0] o_dt;
  logic o_sig, o_busy, o_done, o_ovf, o_udf;
  int errors = 0, checks = 0;
  logic [127:0] q[$];
  always #5 clk = ~clk;
  adc_frame_packer #(.SAMPLE_W(16), .BURST_LEN(4), .BURST_TIMES(2), .FIFO_DEPTH(8), .START_WORDS(4)) u_nom (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .capture_start(n_start), .adc_data(n_data), .adc_valid(n_valid),
    .data_trans(n_dt), .data_ready_trans(n_ready), .data_trans_signal(n_sig), .capture_busy(n_busy),
    .frame_done(n_done), .overflow(n_ovf), .underflow(n_udf));
  adc_frame_packer #(.SAMPLE_W(16), .BURST_LEN(4), .BURST_TIMES(2), .FIFO_DEPTH(4), .START_WORDS(4)) u_ovf (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .capture_start(o_start), .adc_data(o_data), .adc_valid(o_valid),
    .data_trans(o_dt), .data_ready_trans(o_ready), .data_trans_signal(o_sig), .capture_busy(o_busy),
    .frame_done(o_done), .overflow(o_ovf), .underflow(o_udf));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [127:0] mkword(input int b);
    logic [127:0] w;
    for (int k = 0; k < 8; k++) w[k*16 +: 16] = 16'(b + k);
    return w;
  endfunction
  task automatic chk_idle_n(input string tag);
    chk({tag, "_dt"}, n_dt, '0);
    chk({tag, "_sig"}, 128'(n_sig), 0);
    chk({tag, "_busy"}, 128'(n_busy), 0);
    chk({tag, "_done"}, 128'(n_done), 0);
    chk({tag, "_flags"}, 128'({n_ovf, n_udf}), 0);
  endtask
  // master model pops only once the strobe has been seen; partial mode stops before the last pops
  task automatic run_frame(input int base, input bit partial);
    int cyc, limit, sent, pops, dones, highs, rises, exp_rise, last_pop, last_send;
    bit prev_sig, seen, first;
    q.delete();
    cyc = 0; limit = 600; sent = 0; pops = 0; dones = 0; highs = 0; rises = 0;
    exp_rise = -1; last_pop = -10; last_send = 1000; prev_sig = 0; seen = 0; first = 1;
    n_start = 1; tick; n_start = 0;
    chk("busy_after_start", 128'(n_busy), 1);
    while (cyc < limit && !(partial && sent >= 64 && cyc >= last_send + 3)) begin
      if (n_sig && !prev_sig) begin
        rises++;
        chk("strobe_rise_cycle", 128'(cyc), 128'(exp_rise));
      end
      if (n_sig) begin highs++; seen = 1; end
      prev_sig = n_sig;
      if (n_done) begin
        dones++;
        chk("done_cycle", 128'(cyc), 128'(last_pop + 1));
        limit = cyc + 6;
      end
      n_ready = seen && q.size() > 0 && (cyc % 3 != 2) && !(partial && pops >= 5);
      if (n_ready) begin
        if (first && base == 0) chk("first_word", n_dt, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
        first = 0;
        chk("pop_data", n_dt, q.pop_front());
        pops++;
        last_pop = cyc;
      end
      n_valid = 1;
      if (sent < 64) begin
        n_data = 16'(base + sent);
        if (sent % 8 == 7) begin
          q.push_back(mkword(base + sent - 7));
          if (sent == 31) exp_rise = cyc + 2;
        end
        sent++;
        last_send = cyc;
      end else n_data = 16'hdead;
      tick;
      cyc++;
    end
    n_ready = 0; n_valid = 0;
    if (partial) begin
      chk("partial_state_drain", 128'(u_nom.state_q), 128'(2));
      chk("partial_no_done", 128'(dones), 0);
    end else begin
      chk("pops", 128'(pops), 8);
      chk("done_count", 128'(dones), 1);
      chk("strobe_high_cycles", 128'(highs), 4);
      chk("strobe_rises", 128'(rises), 1);
      chk("queue_empty", 128'(q.size()), 0);
      chk("end_busy", 128'(n_busy), 0);
      chk("end_flags", 128'({n_ovf, n_udf}), 0);
    end
  endtask
  initial begin
    repeat (3) tick;
    rst = 0;
    chk_idle_n("reset_n");
    chk("reset_o", 128'({o_dt, o_sig, o_busy, o_done, o_ovf, o_udf}), 0);
    run_frame(0, 0);
    run_frame(1000, 1);
    rst = 1; tick; rst = 0;
    chk_idle_n("reset_mid_drain");
    run_frame(5000, 0);
    n_start = 1; tick; n_start = 0;
    chk("udf_before", 128'(n_udf), 0);
    n_ready = 1; tick; n_ready = 0;
    chk("udf_set", 128'(n_udf), 1);
    chk("udf_popped", 128'(u_nom.words_popped_q), 1);
    chk("udf_rd_ptr", 128'(u_nom.u_fifo.rd_ptr_q), 0);
    chk("udf_wr_ptr", 128'(u_nom.u_fifo.wr_ptr_q), 0);
    chk("udf_ovf", 128'(n_ovf), 0);
    o_start = 1; tick; o_start = 0;
    for (int i = 0; i < 64; i++) begin
      if (i == 39) chk("ovf_before_5th", 128'(o_ovf), 0);
      o_valid = 1; o_data = 16'(100 + i);
      tick;
      if (i == 39) chk("ovf_after_5th", 128'(o_ovf), 1);
    end
    o_valid = 0;
    tick; tick;
    chk("ovf_packed", 128'(u_ovf.words_packed_q), 8);
    chk("ovf_state_drain", 128'(u_ovf.state_q), 128'(2));
    chk("ovf_head", o_dt, mkword(100));
    rst = 1; tick; rst = 0;
    chk("ovf_reset", 128'({o_dt, o_sig, o_busy, o_done, o_ovf, o_udf}), 0);
    o_start = 1; tick; o_start = 0;
    for (int i = 0; i < 39; i++) begin
      o_valid = 1; o_data = 16'(200 + i);
      tick;
      if (i == 31) chk("fp_full_count", 128'(u_ovf.fifo_count), 4);
    end
    chk("fp_head", o_dt, mkword(200));
    o_ready = 1; o_valid = 1; o_data = 16'(239);
    tick;
    o_ready = 0; o_valid = 0;
    chk("fp_count_same", 128'(u_ovf.fifo_count), 4);
    chk("fp_ovf_clear", 128'(o_ovf), 0);
    chk("fp_udf_clear", 128'(o_udf), 0);
    for (int j = 1; j <= 4; j++) begin
      o_ready = 1;
      chk("fp_order", o_dt, mkword(200 + 8 * j));
      tick;
    end
    o_ready = 0;
    chk("fp_drained", 128'(u_ovf.fifo_count), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
